// File: rtl/ntt_btf_sched.sv
// Butterfly scheduler: walks one shared butterfly through all LOGN stages of
// an in-place NTT (CT/DIT) or INTT (GS/DIF). It generates the read and twiddle
// addresses and replays each read pair as a write pair L cycles later.
// Between stages it waits in a drain state, so every write of a stage is
// issued before the first read of the next stage.
//
//   state | meaning
//   IDLE  | waiting for start; fault_flag holds the last result
//   RUN   | one butterfly read per cycle, index i = 0..N/2-1
//   DRAIN | no reads; waits L cycles for the stage's write-backs to finish
//   DONE  | one-cycle completion pulse
module ntt_btf_sched #(
  parameter int LOGN    = 8,
  parameter int MEM_LAT = 1,
  parameter int BTF_LAT = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            inv,
  output logic            busy,
  output logic            done,
  output logic            fault_flag,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-1:0] tw_addr,
  output logic [1:0]      btf_op,
  output logic            btf_sel_dit,
  output logic            btf_en_div2,
  input  logic            btf_fault,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
);

  localparam int L  = MEM_LAT + BTF_LAT;
  localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam int IW = LOGN - 1;
  localparam int CW = $clog2(L + 1);
  localparam int DW = 1 + 2 * LOGN;

  localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);
  localparam logic [IW-1:0] I_LAST = '1;
  localparam logic [CW-1:0] CNT_L  = CW'(L);
  localparam logic [CW-1:0] CNT_1  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       s_q, s_d;
  logic [IW-1:0]       i_q, i_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                fault_q, fault_d;
  logic                sel_dit_q, sel_dit_d;
  logic                en_div2_q, en_div2_d;
  logic [L-1:0][DW-1:0] dl_q, dl_d;

  logic [SW-1:0]   lh;
  logic [LOGN-1:0] i_ext, h, g, j, addr_a, addr_b, tw;

  // State, counters, mode latches and write-back delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      s_q       <= '0;
      i_q       <= '0;
      cnt_q     <= '0;
      fault_q   <= 1'b0;
      sel_dit_q <= 1'b0;
      en_div2_q <= 1'b0;
      dl_q      <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      i_q       <= i_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      sel_dit_q <= sel_dit_d;
      en_div2_q <= en_div2_d;
      dl_q      <= dl_d;
    end
  end

  // Next-state logic: stage/index sequencing and the inter-stage drain barrier.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    i_d       = i_q;
    cnt_d     = cnt_q;
    fault_d   = fault_q | (wr_en & btf_fault);
    sel_dit_d = sel_dit_q;
    en_div2_d = en_div2_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          s_d       = '0;
          i_d       = '0;
          fault_d   = 1'b0;
          sel_dit_d = ~inv;
          en_div2_d = inv;
        end
      end
      RUN: begin
        // i wraps back to 0 on the last butterfly, ready for the next stage.
        i_d = i_q + 1'b1;
        if (i_q == I_LAST) begin
          state_d = DRAIN;
          cnt_d   = CNT_L;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_1) begin
          if (s_q == S_LAST) begin
            state_d = DONE;
          end else begin
            s_d     = s_q + 1'b1;
            state_d = RUN;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address generation. The half-span h is a power of two, so i/h and i%h
  // reduce to a shift and a mask by lh = log2(h). The twiddle base is
  // 1 << (LOGN-1-lh) in both directions.
  always_comb begin
    lh     = en_div2_q ? s_q : (S_LAST - s_q);
    i_ext  = {1'b0, i_q};
    h      = LOGN'(1) << lh;
    g      = i_ext >> lh;
    j      = i_ext & (h - LOGN'(1));
    addr_a = ((g << lh) << 1) | j;
    addr_b = addr_a + h;
    tw     = (LOGN'(1) << (S_LAST - lh)) + g;
  end

  // Outputs: addresses are zeroed outside RUN so the delay line only carries
  // live pairs.
  always_comb begin
    rd_en       = (state_q == RUN);
    rd_addr_a   = rd_en ? addr_a : '0;
    rd_addr_b   = rd_en ? addr_b : '0;
    tw_addr     = rd_en ? tw : '0;
    busy        = (state_q == RUN) || (state_q == DRAIN);
    done        = (state_q == DONE);
    fault_flag  = fault_q;
    btf_op      = 2'd0;
    btf_sel_dit = sel_dit_q;
    btf_en_div2 = en_div2_q;
    {wr_en, wr_addr_a, wr_addr_b} = dl_q[L-1];
  end

  // Write-back delay line: each read pair re-emerges as its write pair L cycles later.
  always_comb begin
    dl_d    = dl_q;
    dl_d[0] = {rd_en, rd_addr_a, rd_addr_b};
    for (int k = 1; k < L; k++) begin
      dl_d[k] = dl_q[k-1];
    end
  end

endmodule

// File: tb/tb_ntt_btf_sched.sv
// Bench for ntt_btf_sched at LOGN=3, L=3. For each transform, a reference
// schedule of (cycle, a, b, tw) reads is queued at start. Every observed read
// is popped and compared against it, and a matching write expectation is
// queued for L cycles later.
module tb_ntt_btf_sched;

  localparam int LOGN    = 3;
  localparam int MEM_LAT = 1;
  localparam int BTF_LAT = 2;
  localparam int L       = MEM_LAT + BTF_LAT;
  localparam int N       = 1 << LOGN;
  localparam int DONE_CYC = 1 + LOGN * (N / 2 + L);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            inv = 1'b0;
  logic            btf_fault = 1'b0;
  logic            busy, done, fault_flag, rd_en, wr_en;
  logic            btf_sel_dit, btf_en_div2;
  logic [1:0]      btf_op;
  logic [LOGN-1:0] rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
  } xact_t;

  xact_t rdq[$];
  xact_t wrq[$];

  int vectors = 0;
  int errors  = 0;

  ntt_btf_sched #(.LOGN(LOGN), .MEM_LAT(MEM_LAT), .BTF_LAT(BTF_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .inv(inv),
    .busy(busy), .done(done), .fault_flag(fault_flag),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .btf_op(btf_op), .btf_sel_dit(btf_sel_dit), .btf_en_div2(btf_en_div2),
    .btf_fault(btf_fault),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  task automatic build_schedule(input logic inv_i);
    int n;
    int h;
    xact_t x;
    rdq.delete();
    wrq.delete();
    for (int s = 0; s < LOGN; s++) begin
      h = inv_i ? (1 << s) : (N >> (s + 1));
      n = 0;
      for (int g = 0; g < N / (2 * h); g++) begin
        for (int j = 0; j < h; j++) begin
          x.cyc = 1 + s * (N / 2 + L) + n;
          x.a   = 2 * g * h + j;
          x.b   = 2 * g * h + j + h;
          x.tw  = inv_i ? ((N >> (s + 1)) + g) : ((1 << s) + g);
          rdq.push_back(x);
          n++;
        end
      end
    end
  endtask

  // Runs one transform. fault_idx: write index that gets btf_fault (-1 none).
  // busy_start_cyc: cycle at which a stray start is pulsed (-1 none).
  // rst_at: cycle at which reset is asserted and the run abandoned (-1 none).
  task automatic run_xform(input logic inv_i, input int fault_idx,
                           input int busy_start_cyc, input int rst_at, input string nm);
    int    cyc;
    int    wr_cnt;
    bit    done_seen;
    bit    exp_fault;
    xact_t x;
    xact_t w;
    exp_fault = (fault_idx >= 0);
    build_schedule(inv_i);
    @(negedge clk);
    start = 1'b1;
    inv   = inv_i;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    wr_cnt = 0;
    done_seen = 1'b0;
    vectors++;
    if (fault_flag !== 1'b0) begin
      errors++;
      $display("FAIL %s fault_clear: got %0b want 0", nm, fault_flag);
    end
    while (!done_seen && cyc < 100) begin
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        vectors++;
        if ({rd_en, wr_en, busy, done, fault_flag, rd_addr_a, rd_addr_b, tw_addr,
             wr_addr_a, wr_addr_b, btf_sel_dit, btf_en_div2, btf_op} !== '0) begin
          errors++;
          $display("FAIL %s rst_outputs: rd_en=%0b wr_en=%0b busy=%0b ra=%0d rb=%0d tw=%0d want all 0",
                   nm, rd_en, wr_en, busy, rd_addr_a, rd_addr_b, tw_addr);
        end
        btf_fault = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rdq.delete();
        wrq.delete();
        for (int k = 0; k < L + 2; k++) begin
          @(posedge clk);
          #1;
          vectors++;
          if (wr_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s post_rst: wr_en=%0b busy=%0b want 0 0", nm, wr_en, busy);
          end
        end
        return;
      end
      btf_fault = (wr_en === 1'b1) && (wr_cnt == fault_idx);
      start     = (cyc == busy_start_cyc);
      if (rd_en === 1'b1) begin
        vectors++;
        if (rdq.size() == 0) begin
          errors++;
          $display("FAIL %s rd_extra: got read at cycle %0d want none", nm, cyc);
        end else begin
          x = rdq.pop_front();
          if (x.cyc != cyc || rd_addr_a !== x.a[LOGN-1:0] || rd_addr_b !== x.b[LOGN-1:0] ||
              tw_addr !== x.tw[LOGN-1:0]) begin
            errors++;
            $display("FAIL %s rd: got cyc=%0d (%0d,%0d) tw=%0d want cyc=%0d (%0d,%0d) tw=%0d",
                     nm, cyc, rd_addr_a, rd_addr_b, tw_addr, x.cyc, x.a, x.b, x.tw);
          end
          w = x;
          w.cyc = x.cyc + L;
          wrq.push_back(w);
        end
      end
      if (wr_en === 1'b1) begin
        vectors++;
        if (wrq.size() == 0) begin
          errors++;
          $display("FAIL %s wr_extra: got write at cycle %0d want none", nm, cyc);
        end else begin
          w = wrq.pop_front();
          if (w.cyc != cyc || wr_addr_a !== w.a[LOGN-1:0] || wr_addr_b !== w.b[LOGN-1:0]) begin
            errors++;
            $display("FAIL %s wr: got cyc=%0d (%0d,%0d) want cyc=%0d (%0d,%0d)",
                     nm, cyc, wr_addr_a, wr_addr_b, w.cyc, w.a, w.b);
          end
        end
        wr_cnt++;
      end
      vectors++;
      if (btf_sel_dit !== ~inv_i || btf_en_div2 !== inv_i || btf_op !== 2'd0) begin
        errors++;
        $display("FAIL %s mode: got dit=%0b div2=%0b op=%0d want dit=%0b div2=%0b op=0",
                 nm, btf_sel_dit, btf_en_div2, btf_op, ~inv_i, inv_i);
      end
      vectors++;
      if (done === 1'b1) begin
        done_seen = 1'b1;
        if (cyc != DONE_CYC || busy !== 1'b0 || fault_flag !== exp_fault) begin
          errors++;
          $display("FAIL %s done: got cyc=%0d busy=%0b fault=%0b want cyc=%0d busy=0 fault=%0b",
                   nm, cyc, busy, fault_flag, DONE_CYC, exp_fault);
        end
      end else if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy: got %0b at cycle %0d want 1", nm, busy, cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    btf_fault = 1'b0;
    start = 1'b0;
    vectors++;
    if (!done_seen) begin
      errors++;
      $display("FAIL %s timeout: got no done by cycle %0d want done at %0d", nm, cyc, DONE_CYC);
    end
    vectors++;
    if (rdq.size() != 0 || wrq.size() != 0) begin
      errors++;
      $display("FAIL %s leftover: got %0d reads %0d writes pending want 0 0", nm, rdq.size(), wrq.size());
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0 ||
          fault_flag !== exp_fault) begin
        errors++;
        $display("FAIL %s idle: got done=%0b busy=%0b rd=%0b wr=%0b fault=%0b want 0 0 0 0 %0b",
                 nm, done, busy, rd_en, wr_en, fault_flag, exp_fault);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({busy, done, fault_flag, rd_en, wr_en, rd_addr_a, rd_addr_b, tw_addr,
         wr_addr_a, wr_addr_b, btf_op, btf_sel_dit, btf_en_div2} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b rd=%0b wr=%0b dit=%0b want all 0",
               busy, rd_en, wr_en, btf_sel_dit);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%0b rd=%0b wr=%0b done=%0b want 0", busy, rd_en, wr_en, done);
    end
  endtask

  task automatic test_forward();
    run_xform(1'b0, -1, -1, -1, "fwd");
  endtask

  task automatic test_inverse();
    run_xform(1'b1, -1, -1, -1, "inv");
  endtask

  task automatic test_fault();
    run_xform(1'b0, 5, -1, -1, "fault");
    run_xform(1'b1, -1, -1, -1, "fault_clean");
  endtask

  task automatic test_back_to_back();
    run_xform(1'b0, -1, 5, -1, "busy_start");
    run_xform(1'b1, -1, DONE_CYC - 1, -1, "busy_start_late");
  endtask

  task automatic test_mid_reset();
    run_xform(1'b0, -1, -1, 10, "mid_rst");
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      errors++;
      $display("FAIL start_with_rst: got busy=%0b rd=%0b want 0 0", busy, rd_en);
    end
    run_xform(1'b0, -1, -1, -1, "after_rst");
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_fault();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
